// File: rtl/axi_pkg.sv
// Shared AXI types: burst encodings, response codes and default widths.
// Used by both the write and the read responders.
package axi_pkg;

    localparam int unsigned AxiIdW   = 12;
    localparam int unsigned AxiDataW = 64;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } burst_t;

    typedef logic [1:0] resp_t;

    localparam resp_t RespOkay   = 2'b00;
    localparam resp_t RespExokay = 2'b01;
    localparam resp_t RespSlverr = 2'b10;
    localparam resp_t RespDecerr = 2'b11;

    // Encodings are ordered by severity, so the larger code wins.
    function automatic resp_t resp_merge(resp_t a, resp_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic wrap_len_ok(logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_slave_w_responder_if.sv
// AXI write-channel bundle (AW, W, B) between an AXI master and the write responder.
interface axi_slave_w_responder_if #(
    parameter int unsigned ID_W   = 12,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   s_axi_awid;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic [7:0]        s_axi_awlen;
    logic [2:0]        s_axi_awsize;
    logic [1:0]        s_axi_awburst;
    logic              s_axi_awvalid;
    logic              s_axi_awready;

    logic [ID_W-1:0]   s_axi_wid;
    logic [DATA_W-1:0] s_axi_wdata;
    logic [STRB_W-1:0] s_axi_wstrb;
    logic              s_axi_wlast;
    logic              s_axi_wvalid;
    logic              s_axi_wready;

    logic [ID_W-1:0]   s_axi_bid;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready
    );

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready
    );

endinterface

// File: rtl/axi_burst_addr_next.sv
// Combinational next-beat byte address for FIXED, INCR and WRAP bursts.
// Shared between the write and read responders.
module axi_burst_addr_next
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  burst_t            burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] total;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        step  = ADDR_W'(1) << size;
        incr  = addr + step;
        total = (ADDR_W'(len) + ADDR_W'(1)) << size;
        mask  = total - ADDR_W'(1);
        next_addr = addr;
        case (burst)
            BurstIncr: next_addr = incr;
            // Upper bits stay on the wrap boundary, low bits roll over within the window.
            BurstWrap: next_addr = (addr & ~mask) | (incr & mask);
            default:   next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_w_responder.sv
// AXI write responder: takes one AW burst, writes its W beats to a word-addressed memory port
// and returns a single B response carrying the AW ID.
module axi_slave_w_responder
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = AxiIdW,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = AxiDataW,
    parameter int unsigned MEM_AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_slave_w_responder_if.slave s_axi,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF    = $clog2(STRB_W);
    localparam logic [2:0]  OFF3   = 3'(OFF);

    typedef enum logic [1:0] {StIdle, StData, StResp} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    burst_t            burst_q, burst_d;
    logic [7:0]        cnt_q, cnt_d;
    resp_t             err_q, err_d;
    logic              bad_q, bad_d;

    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    resp_t             bresp_q, bresp_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

    logic              aw_hs, w_hs, b_hs;
    logic              aw_bad;
    logic              beat_last, beat_dec, beat_id_bad, beat_last_bad, beat_write;
    resp_t             beat_err;
    logic [ADDR_W-1:0] addr_nxt;

    axi_burst_addr_next #(
        .ADDR_W(ADDR_W)
    ) u_addr_next (
        .addr     (addr_q),
        .size     (size_q),
        .len      (len_q),
        .burst    (burst_q),
        .next_addr(addr_nxt)
    );

    // Handshakes qualify on the registered readies, which are only set in their own state.
    assign aw_hs = s_axi.s_axi_awvalid & awready_q;
    assign w_hs  = s_axi.s_axi_wvalid & wready_q;
    assign b_hs  = bvalid_q & s_axi.s_axi_bready;

    // Burst-wide conditions that suppress every write of the burst.
    assign aw_bad = (s_axi.s_axi_awsize > OFF3) ||
                    (s_axi.s_axi_awburst == BurstRsvd) ||
                    ((s_axi.s_axi_awburst == BurstWrap) && !wrap_len_ok(s_axi.s_axi_awlen));

    assign beat_last     = (cnt_q == len_q);
    assign beat_dec      = |addr_q[ADDR_W-1:MEM_AW+OFF];
    assign beat_id_bad   = (s_axi.s_axi_wid != id_q);
    assign beat_last_bad = (s_axi.s_axi_wlast != beat_last);
    assign beat_write    = !bad_q && !beat_dec && !beat_id_bad;
    assign beat_err      = resp_merge(
                               resp_merge(err_q, (beat_id_bad || beat_last_bad) ? RespSlverr
                                                                                 : RespOkay),
                               beat_dec ? RespDecerr : RespOkay);

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        bad_d       = bad_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        unique case (state_q)
            StIdle: begin
                if (aw_hs) begin
                    id_d    = s_axi.s_axi_awid;
                    addr_d  = s_axi.s_axi_awaddr;
                    len_d   = s_axi.s_axi_awlen;
                    size_d  = s_axi.s_axi_awsize;
                    burst_d = burst_t'(s_axi.s_axi_awburst);
                    cnt_d   = 8'd0;
                    bad_d   = aw_bad;
                    err_d   = aw_bad ? RespSlverr : RespOkay;
                    state_d = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    err_d    = beat_err;
                    mem_we_d = beat_write;
                    if (beat_write) begin
                        mem_addr_d  = addr_q[MEM_AW+OFF-1:OFF];
                        mem_wdata_d = s_axi.s_axi_wdata;
                        mem_wstrb_d = s_axi.s_axi_wstrb;
                    end
                    addr_d = addr_nxt;
                    cnt_d  = cnt_q + 8'd1;
                    // Beat count alone ends the burst; wlast only feeds the error status.
                    if (beat_last) begin
                        bid_d   = id_q;
                        bresp_d = beat_err;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (b_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        awready_d = (state_d == StIdle);
        wready_d  = (state_d == StData);
        bvalid_d  = (state_d == StResp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= BurstFixed;
            cnt_q       <= '0;
            err_q       <= RespOkay;
            bad_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= RespOkay;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            bad_q       <= bad_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bid     = bid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign mem_we              = mem_we_q;
    assign mem_addr            = mem_addr_q;
    assign mem_wdata           = mem_wdata_q;
    assign mem_wstrb           = mem_wstrb_q;

endmodule
